crc_frame_checker: RTL and testbench

- Receive-side stage that consumes the serial bit stream produced by the optical link, in the same bit-serial form the CRC8 engine accepts: one bit per valid cycle, bytes LSB-first.
- Rebuilds bytes and runs the CRC8 check over each frame: poly 0x1D, init 0xFF, reflected in and out, xorout 0x00, check 0x97, residue 0x00.
- Forwards payload bytes downstream and strips the trailing CRC byte.
- Raises one verdict pulse per frame.

---
 rtl/crc_frame_checker_if.sv | 24 ++
 rtl/crc_frame_checker.sv | 91 +++++++++
 tb/tb_crc_frame_checker.sv | 132 +++++++++++++
 3 files changed

// File: rtl/crc_frame_checker_if.sv
// crc_frame_checker_if: serial bit input, payload byte output and per-frame verdict
interface crc_frame_checker_if #(
  parameter int MAX_BYTES = 64,
  parameter int LW = $clog2(MAX_BYTES + 2)
);
  logic axiiv;
  logic axiid;
  logic axiov;
  logic [7:0] axiod;
  logic frame_done;
  logic frame_ok;
  logic [LW-1:0] frame_len;
  logic err_align;
  logic err_short;
  logic err_long;
  modport master (
    output axiiv, axiid,
    input axiov, axiod, frame_done, frame_ok, frame_len, err_align, err_short, err_long
  );
  modport slave (
    input axiiv, axiid,
    output axiov, axiod, frame_done, frame_ok, frame_len, err_align, err_short, err_long
  );
endinterface

// File: rtl/crc_frame_checker.sv
// crc_frame_checker: rebuilds LSB-first bytes, checks CRC8 (0x1D, reflected, init 0xFF) and strips the CRC byte
module crc_frame_checker #(
  parameter int MAX_BYTES = 64,
  parameter int LW = $clog2(MAX_BYTES + 2)
) (
  input logic clk,
  input logic rst,
  crc_frame_checker_if.slave bus
);
  typedef enum logic {IDLE, RECV} state_t;
  state_t r_state;
  logic [7:0] r_crc;
  logic [7:0] r_sr;
  logic [7:0] r_hold;
  logic [2:0] r_bitcnt;
  logic [LW-1:0] r_bytecnt;
  logic r_long;
  logic [7:0] w_crc_in;
  logic [7:0] w_crc_next;
  logic [7:0] w_byte;
  logic w_wrap;
  logic w_pend;
  logic w_emit;
  logic w_align;
  logic w_short;
  // CRC step, byte assembly and end-of-frame verdict terms; a new frame restarts the CRC from 0xFF
  always_comb begin
    w_crc_in = (r_state == IDLE) ? 8'hFF : r_crc;
    w_crc_next = {w_crc_in[6:0], 1'b0} ^ ((w_crc_in[7] ^ bus.axiid) ? 8'h1D : 8'h00);
    w_byte = {bus.axiid, r_sr[7:1]};
    w_wrap = r_bitcnt == 3'd7;
    w_pend = r_bytecnt != '0;
    w_emit = r_bytecnt <= LW'(MAX_BYTES);
    w_align = r_bitcnt != 3'd0;
    w_short = r_bytecnt < LW'(2);
  end
  // Frame FSM: the held byte is only forwarded once a following byte proves it is not the CRC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_crc <= 8'hFF;
      r_sr <= '0;
      r_hold <= '0;
      r_bitcnt <= '0;
      r_bytecnt <= '0;
      r_long <= 1'b0;
      bus.axiov <= 1'b0;
      bus.axiod <= '0;
      bus.frame_done <= 1'b0;
      bus.frame_ok <= 1'b0;
      bus.frame_len <= '0;
      bus.err_align <= 1'b0;
      bus.err_short <= 1'b0;
      bus.err_long <= 1'b0;
    end else begin
      bus.axiov <= 1'b0;
      bus.frame_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.axiiv) begin
          r_state <= RECV;
          r_crc <= w_crc_next;
          r_sr <= w_byte;
          r_bitcnt <= 3'd1;
          r_bytecnt <= '0;
          r_long <= 1'b0;
        end
      end else if (bus.axiiv) begin
        r_crc <= w_crc_next;
        r_sr <= w_byte;
        r_bitcnt <= r_bitcnt + 3'd1;
        if (w_wrap) begin
          r_bytecnt <= (r_bytecnt == LW'(MAX_BYTES + 2)) ? r_bytecnt : r_bytecnt + LW'(1);
          r_hold <= w_byte;
          if (w_pend) begin
            bus.axiov <= w_emit;
            bus.axiod <= w_emit ? r_hold : bus.axiod;
            r_long <= r_long | ~w_emit;
          end
        end
      end else begin
        r_state <= IDLE;
        bus.frame_done <= 1'b1;
        bus.frame_len <= w_pend ? r_bytecnt - LW'(1) : '0;
        bus.err_align <= w_align;
        bus.err_short <= w_short;
        bus.err_long <= r_long;
        bus.frame_ok <= (r_crc == 8'h00) & ~w_align & ~w_short & ~r_long;
      end
    end
  end
endmodule

// File: tb/tb_crc_frame_checker.sv
// tb_crc_frame_checker: directed frames with a byte/verdict scoreboard drained by a negedge monitor
module tb_crc_frame_checker;
  localparam int MAX = 64;
  localparam int LW = $clog2(MAX + 2);
  typedef struct packed {
    logic ok;
    logic [LW-1:0] len;
    logic al;
    logic sh;
    logic lg;
  } verd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] q_byte[$];
  verd_t q_verd[$];
  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  crc_frame_checker_if #(.MAX_BYTES(MAX)) bus();
  crc_frame_checker #(.MAX_BYTES(MAX)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      bus.axiiv = 1'b1;
      bus.axiid = b[i];
      @(posedge clk);
      #1;
    end
  endtask
  task automatic gap(input int n);
    bus.axiiv = 1'b0;
    bus.axiid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_msg(input logic [7:0] crc, input int last_bits);
    for (int i = 0; i < 9; i++) send_bits(msg[i], 8);
    send_bits(crc, last_bits);
  endtask
  task automatic expect_msg(input int n, input verd_t v);
    for (int i = 0; i < n; i++) q_byte.push_back(msg[i]);
    q_verd.push_back(v);
  endtask
  task automatic chk_clear(input string tag);
    chk({tag, "_axiov"}, bus.axiov, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_frame_ok"}, bus.frame_ok, 0);
    chk({tag, "_frame_len"}, bus.frame_len, 0);
    chk({tag, "_err_align"}, bus.err_align, 0);
    chk({tag, "_err_short"}, bus.err_short, 0);
    chk({tag, "_err_long"}, bus.err_long, 0);
  endtask
  // Monitor: every payload byte and every verdict pulse is matched against the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.axiov && bus.frame_done) chk("axiov_with_frame_done", 1, 0);
      if (bus.axiov) begin
        if (q_byte.size() == 0) chk("unexpected_byte", bus.axiod, -1);
        else chk("payload_byte", bus.axiod, q_byte.pop_front());
      end
      if (bus.frame_done) begin
        if (q_verd.size() == 0) chk("unexpected_frame_done", 1, 0);
        else begin
          verd_t v;
          v = q_verd.pop_front();
          chk("frame_ok", bus.frame_ok, v.ok);
          chk("frame_len", bus.frame_len, v.len);
          chk("err_align", bus.err_align, v.al);
          chk("err_short", bus.err_short, v.sh);
          chk("err_long", bus.err_long, v.lg);
        end
      end
    end
  end
  initial begin
    bus.axiiv = 1'b0;
    bus.axiid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_clear("reset");
    chk("reset_axiod", bus.axiod, 0);
    rst = 1'b0;
    gap(1);
    expect_msg(9, '{ok: 1'b1, len: LW'(9), al: 1'b0, sh: 1'b0, lg: 1'b0});
    send_msg(8'h97, 8);
    gap(2);
    expect_msg(9, '{ok: 1'b0, len: LW'(9), al: 1'b0, sh: 1'b0, lg: 1'b0});
    send_msg(8'h96, 8);
    gap(2);
    expect_msg(8, '{ok: 1'b0, len: LW'(8), al: 1'b1, sh: 1'b0, lg: 1'b0});
    send_msg(8'h97, 5);
    gap(2);
    q_verd.push_back('{ok: 1'b0, len: LW'(0), al: 1'b0, sh: 1'b1, lg: 1'b0});
    send_bits(8'hAB, 8);
    gap(2);
    q_byte.push_back(8'h31);
    q_byte.push_back(8'h32);
    send_bits(8'h31, 8);
    send_bits(8'h32, 8);
    send_bits(8'h33, 8);
    send_bits(8'h34, 6);
    rst = 1'b1;
    bus.axiiv = 1'b0;
    @(posedge clk);
    #1;
    chk_clear("abort");
    rst = 1'b0;
    gap(1);
    expect_msg(9, '{ok: 1'b1, len: LW'(9), al: 1'b0, sh: 1'b0, lg: 1'b0});
    send_msg(8'h97, 8);
    gap(1);
    expect_msg(9, '{ok: 1'b1, len: LW'(9), al: 1'b0, sh: 1'b0, lg: 1'b0});
    send_msg(8'h97, 8);
    gap(1);
    for (int i = 0; i < MAX; i++) q_byte.push_back(8'(i * 3 + 1));
    q_verd.push_back('{ok: 1'b0, len: LW'(MAX + 1), al: 1'b0, sh: 1'b0, lg: 1'b1});
    for (int i = 0; i <= MAX; i++) send_bits(8'(i * 3 + 1), 8);
    send_bits(8'h00, 8);
    gap(4);
    chk("bytes_left_in_queue", q_byte.size(), 0);
    chk("verdicts_left_in_queue", q_verd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
